bit_serial_adder: RTL and testbench
===================================

// Module: bit_serial_adder
// PURPOSE
//  Multi-cycle adder for WIDTH-bit operands. Processes one bit per clock, LSB first.
//  Datapath per bit: full-add built from two half-add cells plus a carry register.
//  Parallel operands are loaded on start; the parallel sum and carry-out are presented at done.
//  Sits downstream of the half-add cell as its first sequential consumer.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits; legal range >= 1
// PORTS
//  clk    in   1      rising-edge clock; single clock domain
//  rst    in   1      synchronous reset, active-high; sampled on rising clk
//  start  in   1      request a new addition; honoured only while ready=1
//  a      in   WIDTH  operand A; sampled on the accepting edge only
//  b      in   WIDTH  operand B; sampled on the accepting edge only
//  cin    in   1      carry-in; sampled on the accepting edge only
//  ready  out  1      1 in IDLE (can accept start)
//  busy   out  1      1 in RUN
//  done   out  1      1-cycle pulse: sum/cout valid
//  sum    out  WIDTH  result; held until next accept or reset
//  cout   out  1      carry-out; held with sum
// BEHAVIOUR
//  Reset (rst=1 at an edge; overrides everything, including start):
//   - state=IDLE, ready=1, busy=0, done=0.
//   - sum=0, cout=0; internal shift registers, carry and bit counter cleared.
//  FSM states: IDLE, RUN, DONE.
//   - IDLE: ready=1. On start=1 at edge k:
//       latch a, b; carry<=cin; cnt<=0; go to RUN.
//       sum and cout are cleared at the same edge.
//     Otherwise stay in IDLE; sum/cout hold.
//   - RUN: busy=1, ready=0. Each edge:
//       s = a_sh[0]^b_sh[0]^carry; carry <= majority(a_sh[0], b_sh[0], carry).
//       s shifts into sum MSB, sum shifts right; a_sh, b_sh shift right.
//       cnt increments.
//     When cnt==WIDTH-1 at an edge: last bit is processed, cout<=final carry,
//       and the state goes to DONE. That edge is k+WIDTH.
//   - DONE: done=1, busy=0, ready=0 for exactly one cycle; go to IDLE at edge k+WIDTH+1.
//  Latency: accepted at edge k -> done visible after edge k+WIDTH.
//   Minimum accept-to-accept interval is WIDTH+2 edges.
//  start is ignored in RUN and DONE; it is not queued.
//  a, b and cin may change freely after the accepting edge.
//  sum/cout are undefined-free but intermediate during RUN; consumers use them only at done.
//  Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1), with no overflow flag.
//  Counter width: $clog2(WIDTH+1). WIDTH=1 gives RUN lasting exactly one edge.
//  Reset mid-RUN or in DONE: abandon the operation, return to IDLE, no done pulse.
// TESTING
//  T1 WIDTH=8: a=8'h3C, b=8'h55, cin=0, start pulse
//     -> busy for 8 cycles; done 1 cycle; sum=8'h91, cout=0.
//  T2 a=8'hFF, b=8'h01, cin=0
//     -> sum=8'h00, cout=1 (carry ripple through all bits).
//  T3 a=8'hFF, b=8'hFF, cin=1
//     -> sum=8'hFF, cout=1.
//     Also a=0, b=0, cin=0 -> sum=0, cout=0.
//  T4 accept 8'h10+8'h20; drive start=1 with a=8'hAA, b=8'h55 on RUN cycle 3
//     -> ignored; done gives sum=8'h30, cout=0; ready returns 1 next cycle.
//  T5 accept 8'h7F+8'h01; assert rst for 1 cycle at RUN cycle 4
//     -> next cycle ready=1, busy=0, done=0, sum=0, cout=0; no done pulse ever.
//     Then 8'h01+8'h02 -> sum=8'h03.
//  T6 hold start=1 continuously with random a/b/cin for 200 ops
//     -> accepts every 10 cycles; each done matches the a+b+cin reference model.

Source files
------------

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: WIDTH-bit operands summed one bit per clock, LSB first.
// The per-bit full add is two half-add cells plus a carry register.
// Parallel sum/cout are presented with a one-cycle done pulse.

module half_add (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic s0, c0, s_bit, c1, carry_nx;
    logic [WIDTH-1:0] sum_nx;

    // first half-add: operand bits
    half_add u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(s0), .c(c0));
    // second half-add: folds in the running carry
    half_add u_ha1 (.x(s0), .y(carry), .s(s_bit), .c(c1));

    // at most one of c0/c1 can be set, so OR gives the majority carry
    assign carry_nx = c0 | c1;

    // new sum bit enters at the MSB; written this way so WIDTH=1 needs no special case
    always_comb begin
        sum_nx = sum >> 1;
        sum_nx[WIDTH-1] = s_bit;
    end

    // control FSM and serial datapath, all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    sum   <= sum_nx;
                    carry <= carry_nx;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        cout  <= carry_nx;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8) with an expected-result queue.

module tb_bit_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         ready, busy, done, cout;
    logic [W-1:0] sum;

    int checks = 0;
    int failures = 0;
    logic [W:0] sb[$];

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // accept one op (DUT assumed idle), push its reference, wait for done
    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                          output int busy_cyc, output bit got);
        @(negedge clk);
        start = 1'b1; a = ai; b = bi; cin = ci;
        sb.push_back(model(ai, bi, ci));
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        busy_cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({ready, busy, done, cout, sum} !== {3'b100, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL reset_state got rdy/bsy/dn=%b%b%b cout=%b sum=%h exp 100 0 00",
                     ready, busy, done, cout, sum);
        end
    endtask

    task automatic test_basic(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                              input logic [W:0] exp_const, input string name);
        int bc;
        bit got;
        logic [W:0] exp;
        run_op(ai, bi, ci, bc, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_done_timeout got no done exp done", name);
            sb.delete();
            return;
        end
        exp = sb.pop_front();
        checks++;
        if ({cout, sum} !== exp || exp !== exp_const) begin
            failures++;
            $display("FAIL %s_result got=%h exp=%h", name, {cout, sum}, exp_const);
        end
        checks++;
        if (bc != W) begin
            failures++;
            $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, bc, W);
        end
        @(negedge clk);
        checks++;
        if ({ready, busy, done} !== 3'b100) begin
            failures++;
            $display("FAIL %s_after_done got rdy/bsy/dn=%b%b%b exp 100", name, ready, busy, done);
        end
    endtask

    task automatic test_start_ignored();
        bit got = 1'b0;
        int rc = 0;
        logic [W:0] exp;
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        sb.push_back(model(8'h10, 8'h20, 1'b0));
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) rc++;
            if (rc == 3) begin
                start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL ignore_done_timeout got no done exp done");
            sb.delete();
            return;
        end
        exp = sb.pop_front();
        checks++;
        if ({cout, sum} !== exp) begin
            failures++;
            $display("FAIL ignore_result got=%h exp=%h", {cout, sum}, exp);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL ignore_ready_back got rdy=%b dn=%b exp rdy=1 dn=0", ready, done);
        end
        rc = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy || done) rc++;
        end
        checks++;
        if (rc != 0) begin
            failures++;
            $display("FAIL ignore_not_queued got active_cycles=%0d exp=0", rc);
        end
    endtask

    task automatic test_reset_mid_run();
        int rc = 0;
        @(negedge clk);
        start = 1'b1; a = 8'h7F; b = 8'h01; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy) rc++;
            if (rc == 4) break;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({ready, busy, done, cout, sum} !== {3'b100, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL midrun_reset got rdy/bsy/dn=%b%b%b cout=%b sum=%h exp 100 0 00",
                     ready, busy, done, cout, sum);
        end
        rc = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) rc++;
        end
        checks++;
        if (rc != 0) begin
            failures++;
            $display("FAIL midrun_no_done got done_pulses=%0d exp=0", rc);
        end
        test_basic(8'h01, 8'h02, 1'b0, 9'h003, "after_reset");
    endtask

    // start held high: accepts predicted every W+2 cycles, each result checked
    task automatic test_back_to_back();
        int ndone = 0;
        int bad_ctl = 0;
        logic [W:0] exp;
        @(negedge clk);
        for (int n = 0; n < 200 * (W + 2); n++) begin
            if (n % (W + 2) == W + 1) begin
                checks++;
                if (done !== 1'b1 || sb.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_done_missing cycle=%0d got done=%b exp 1", n, done);
                end else begin
                    exp = sb.pop_front();
                    ndone++;
                    if ({cout, sum} !== exp) begin
                        failures++;
                        $display("FAIL b2b_result op=%0d got=%h exp=%h", ndone, {cout, sum}, exp);
                    end
                end
            end else if (done !== 1'b0) begin
                bad_ctl++;
            end
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            start = 1'b1;
            if (n % (W + 2) == 0) begin
                checks++;
                if (ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready cycle=%0d got=%b exp=1", n, ready);
                end
                sb.push_back(model(a, b, cin));
            end else if (ready !== 1'b0) begin
                bad_ctl++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (bad_ctl != 0 || ndone != 200) begin
            failures++;
            $display("FAIL b2b_summary got stray_ctl=%0d dones=%0d exp 0 and 200", bad_ctl, ndone);
        end
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_basic(8'h3C, 8'h55, 1'b0, 9'h091, "t1");
        test_basic(8'hFF, 8'h01, 1'b0, 9'h100, "t2_ripple");
        test_basic(8'hFF, 8'hFF, 1'b1, 9'h1FF, "t3_max");
        test_basic(8'h00, 8'h00, 1'b0, 9'h000, "t3_zero");
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
